// File: rtl/bus_mem_responder_pkg.sv
// Shared definitions for the bus memory responder: command encodings and FSM state type.
package bus_mem_responder_pkg;

    localparam logic BUS_CMD_READ  = 1'b1;
    localparam logic BUS_CMD_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_READ = 3'b010,
        ST_ERR  = 3'b100
    } bus_rsp_state_t;

endpackage

// File: rtl/bus_mem_responder_array.sv
// Single-port synchronous SRAM, byte write enables, 1-cycle registered read.
// Read data holds until the next enabled read, which the responder relies on to stall beats.
module bus_mem_array #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter string       INIT_FILE   = ""
) (
  input  logic                           clk_core,
  input  logic                           en,
  input  logic                           we,
  input  logic [3:0]                     wstrb,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_core) begin
    if (en) begin
      if (we) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (wstrb[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Bus responder backing an on-chip SRAM window: aligned read bursts, strobed single writes,
// and a sticky bus error for out-of-window addresses until acknowledged.
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [26:0] BASE_WORD   = 27'h0,
    parameter int unsigned BURST_LEN   = 4,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk_core,
    input  logic        reset,
    input  logic        cvalid,
    output logic        cready,
    input  logic        cmd,
    input  logic [26:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        rvalid,
    input  logic        rready,
    output logic        rlast,
    output logic [31:0] rdata,
    output logic        error,
    input  logic        eack
);

    localparam int unsigned IW = $clog2(DEPTH_WORDS);
    localparam int unsigned OW = $clog2(BURST_LEN);

    bus_rsp_state_t state_q, state_d;
    logic [IW-OW-1:0] line_q;
    logic [OW-1:0]    beat_q;
    logic [OW-1:0]    beat_nxt;

    logic [26:0]      off;
    logic             in_win;
    logic [IW-1:0]    cmd_idx;
    logic             accept;
    logic             beat;
    logic             is_last;

    logic             mem_en;
    logic             mem_we;
    logic [IW-1:0]    mem_addr;
    logic [31:0]      mem_rdata;

    assign off      = addr - BASE_WORD;
    assign in_win   = (off[26:IW] == '0);
    assign cmd_idx  = off[IW-1:0];
    assign beat_nxt = beat_q + 1'b1;

    // Beats come straight from the array's registered output; stalls hold because no new read is issued.
    assign cready  = (state_q == ST_IDLE) && !reset;
    assign rvalid  = (state_q == ST_READ);
    assign rlast   = rvalid && (beat_q == '1);
    assign rdata   = rvalid ? mem_rdata : '0;
    assign error   = (state_q == ST_ERR);
    assign accept  = cvalid && cready;
    assign beat    = rvalid && rready;
    assign is_last = (beat_q == '1);

    always_comb begin
        state_d  = state_q;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!in_win) begin
                        state_d = ST_ERR;
                    end else if (cmd == BUS_CMD_READ) begin
                        mem_en   = 1'b1;
                        mem_addr = {cmd_idx[IW-1:OW], {OW{1'b0}}};
                        state_d  = ST_READ;
                    end else begin
                        mem_en   = 1'b1;
                        mem_we   = 1'b1;
                        mem_addr = cmd_idx;
                    end
                end
            end
            ST_READ: begin
                if (beat) begin
                    if (is_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        mem_en   = 1'b1;
                        mem_addr = {line_q, beat_nxt};
                    end
                end
            end
            ST_ERR: begin
                if (eack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept && in_win && (cmd == BUS_CMD_READ)) begin
                line_q <= cmd_idx[IW-1:OW];
                beat_q <= '0;
            end else if (beat) begin
                beat_q <= beat_nxt;
            end
        end
    end

    bus_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk_core (clk_core),
        .en       (mem_en),
        .we       (mem_we),
        .wstrb    (wstrb),
        .addr     (mem_addr),
        .wdata    (wdata),
        .rdata    (mem_rdata)
    );

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: expected beats queued from a reference word model.
module tb_bus_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam logic [26:0] BASE  = 27'h400;
    localparam int unsigned BL    = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk_core;
    logic        reset;
    logic        cvalid;
    logic        cready;
    logic        cmd;
    logic [26:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [31:0] rdata;
    logic        error;
    logic        eack;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    logic [31:0] model [DEPTH];
    logic        stalled = 1'b0;
    logic [31:0] stall_data;
    logic        stall_last;

    bus_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_WORD   (BASE),
        .BURST_LEN   (BL),
        .INIT_FILE   ("")
    ) dut (
        .clk_core (clk_core),
        .reset    (reset),
        .cvalid   (cvalid),
        .cready   (cready),
        .cmd      (cmd),
        .addr     (addr),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .rvalid   (rvalid),
        .rready   (rready),
        .rlast    (rlast),
        .rdata    (rdata),
        .error    (error),
        .eack     (eack)
    );

    initial begin
        clk_core = 1'b0;
        forever #5 clk_core = ~clk_core;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish within 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks the beat (if any) taking place at the coming posedge, then advances to the next negedge.
    task automatic step();
        beat_t e;
        if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {31'd0, rvalid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", rdata, e.data);
                chk("rlast", {31'd0, rlast}, {31'd0, e.last});
            end
            stalled = 1'b0;
        end else if (rvalid) begin
            if (stalled) begin
                chk("stall_rdata", rdata, stall_data);
                chk("stall_rlast", {31'd0, rlast}, {31'd0, stall_last});
            end
            stall_data = rdata;
            stall_last = rlast;
            stalled    = 1'b1;
        end else begin
            stalled = 1'b0;
        end
        @(negedge clk_core);
    endtask

    function automatic logic in_window(input logic [26:0] a);
        logic [26:0] o;
        o = a - BASE;
        return o < 27'(DEPTH);
    endfunction

    task automatic push_line(input logic [26:0] a);
        logic [26:0] o;
        beat_t e;
        o = (a - BASE) & ~27'(BL - 1);
        for (int unsigned k = 0; k < BL; k++) begin
            e.data = model[o + 27'(k)];
            e.last = (k == BL - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_write(input logic [26:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [26:0] o;
        chk("cready_before_write", {31'd0, cready}, 32'd1);
        cvalid = 1'b1; cmd = 1'b0; addr = a; wdata = d; wstrb = s;
        step();
        cvalid = 1'b0;
        if (in_window(a)) begin
            o = a - BASE;
            for (int unsigned b = 0; b < 4; b++) begin
                if (s[b]) model[o][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic do_read(input logic [26:0] a);
        chk("cready_before_read", {31'd0, cready}, 32'd1);
        cvalid = 1'b1; cmd = 1'b1; addr = a;
        if (in_window(a)) push_line(a);
        step();
        cvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        chk(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1; cvalid = 1'b0; cmd = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        rready = 1'b0; eack = 1'b0;
        @(negedge clk_core);
        @(negedge clk_core);
        chk("reset_cready", {31'd0, cready}, 32'd0);
        chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
        chk("reset_rlast", {31'd0, rlast}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        @(negedge clk_core);
        chk("post_reset_cready", {31'd0, cready}, 32'd1);

        // Preload via bus writes
        do_write(BASE + 27'd0, 32'h11, 4'hF);
        do_write(BASE + 27'd1, 32'h22, 4'hF);
        do_write(BASE + 27'd2, 32'h33, 4'hF);
        do_write(BASE + 27'd3, 32'h44, 4'hF);

        // Burst read, full throughput
        rready = 1'b1;
        do_read(BASE + 27'd2);
        chk("first_beat_latency", {31'd0, rvalid}, 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("burst_done", exp_q.size(), 32'd0);
        chk("bubble_rvalid", {31'd0, rvalid}, 32'd0);
        chk("bubble_cready", {31'd0, cready}, 32'd1);

        // Backpressure 1,0,0,1
        do_read(BASE + 27'd1);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            rready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        chk("bp_drain", exp_q.size(), 32'd0);
        chk("bp_rvalid_after", {31'd0, rvalid}, 32'd0);
        rready = 1'b1;

        // Strobed write into line 1
        do_write(BASE + 27'd4, 32'h55, 4'hF);
        do_write(BASE + 27'd5, 32'h0, 4'hF);
        do_write(BASE + 27'd6, 32'h66, 4'hF);
        do_write(BASE + 27'd7, 32'h77, 4'hF);
        do_write(BASE + 27'd5, 32'hAABBCCDD, 4'b0101);
        chk("model_strobe", model[5], 32'h00BB00DD);
        do_read(BASE + 27'd5);
        drain("strobe_drain");

        // Top of window
        for (int unsigned k = 252; k < 256; k++) do_write(BASE + 27'(k), 32'hC0DE0000 + k, 4'hF);
        do_read(BASE + 27'd253);
        drain("top_drain");

        // Out of window, explicit eack
        do_read(BASE + 27'(DEPTH));
        chk("oow_error", {31'd0, error}, 32'd1);
        chk("oow_cready", {31'd0, cready}, 32'd0);
        step();
        step();
        chk("oow_error_held", {31'd0, error}, 32'd1);
        chk("oow_no_rvalid", {31'd0, rvalid}, 32'd0);
        eack = 1'b1;
        step();
        chk("oow_error_clear", {31'd0, error}, 32'd0);
        chk("oow_cready_back", {31'd0, cready}, 32'd1);

        // Out of window below base with eack tied high: one-cycle pulse
        do_read(BASE - 27'd1);
        chk("pulse_error", {31'd0, error}, 32'd1);
        step();
        chk("pulse_error_drop", {31'd0, error}, 32'd0);
        chk("pulse_cready", {31'd0, cready}, 32'd1);
        eack = 1'b0;

        // Reset mid-burst after two beats
        do_read(BASE + 27'd0);
        step();
        step();
        reset = 1'b1;
        #1;
        chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("midrst_cready", {31'd0, cready}, 32'd0);
        exp_q.delete();
        stalled = 1'b0;
        @(negedge clk_core);
        reset = 1'b0;
        @(negedge clk_core);
        chk("midrst_rvalid_after", {31'd0, rvalid}, 32'd0);
        do_read(BASE + 27'd3);
        drain("fresh_drain");

        // Write then read next cycle, with a command held through the burst
        do_write(BASE + 27'd9, 32'h99, 4'hF);
        do_write(BASE + 27'd10, 32'hAA, 4'hF);
        do_write(BASE + 27'd11, 32'hBB, 4'hF);
        do_write(BASE + 27'd8, 32'hDEADBEEF, 4'hF);
        do_read(BASE + 27'd9);
        cvalid = 1'b1; cmd = 1'b1; addr = BASE + 27'd1;
        for (int i = 0; i < 4; i++) begin
            chk("held_cready_low", {31'd0, cready}, 32'd0);
            step();
        end
        chk("raw_drain", exp_q.size(), 32'd0);
        chk("held_bubble_rvalid", {31'd0, rvalid}, 32'd0);
        chk("held_accept_cready", {31'd0, cready}, 32'd1);
        push_line(BASE + 27'd1);
        step();
        cvalid = 1'b0;
        drain("held_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
